// File: rtl/accel_pkg.sv
// Shared constants for the NN accelerator datapath and the argmax state encoding.
package accel_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/accel_argmax.sv
// Argmax over the accelerator's class scores: snapshot on a ready rising edge,
// scan one score per cycle, and hold the winner until the core acknowledges it.
module accel_argmax
    import accel_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          accel_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores,
    input  logic                          clear,
    input  logic                          ack,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             max_score,
    output logic                          overrun
);

    // Handshake: done is a level held from the end of the scan until the cycle
    // ack (a one-cycle pulse) is sampled high in DONE; class_idx/max_score are
    // stable for that whole window, and ack in any other state is ignored.

    state_t            state;
    logic              rdy_q;
    logic              rise;
    logic [DATA_W-1:0] snap [0:NUM_CLASSES-1];
    logic [DATA_W-1:0] run_max;
    logic [IDX_W-1:0]  run_idx;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] cand;
    logic              cand_gt;
    logic              capture;

    assign rise    = accel_ready & ~rdy_q;
    assign capture = (state == ST_IDLE) & rise & ~clear;

    always_comb begin
        cand    = snap[ptr];
        cand_gt = $signed(cand) > $signed(run_max);
    end

    // Snapshot is pure data; it needs no reset because run_max/run_idx gate its use.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                snap[k] <= scores[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            rdy_q   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            run_max <= '0;
            run_idx <= '0;
            ptr     <= '0;
        end else begin
            rdy_q <= accel_ready;
            if (clear) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            run_max <= scores[DATA_W-1:0];
                            run_idx <= '0;
                            ptr     <= IDX_W'(1);
                            busy    <= 1'b1;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (rise) begin
                            overrun <= 1'b1;
                        end
                        // Strict greater-than keeps the lowest index on ties.
                        if (cand_gt) begin
                            run_max <= cand;
                            run_idx <= ptr;
                        end
                        if (ptr == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (ack) begin
                            done    <= 1'b0;
                            overrun <= rise;
                            state   <= ST_IDLE;
                        end else if (rise) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign class_idx = run_idx;
    assign max_score = run_max;

endmodule
